gps_uart_rx: RTL and testbench
==============================

# gps_uart_rx

Asynchronous-serial receiver for the GPS module's NMEA output (8 data bits, no parity, 1 stop bit, LSB first). It synchronises the raw `rx` line, detects and qualifies start bits, samples each bit at its midpoint, and presents every received byte as `char` with a one-cycle `valid` strobe. It sits directly upstream of the NMEA sentence parser and drives that parser's `char`/`valid` inputs without any handshake.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz.
- `BAUD`, 9600, serial bit rate; derived `CLKS_PER_BIT = CLK_FREQ/BAUD` (integer divide, must be ≥ 4), `HALF = CLKS_PER_BIT/2`.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `rx`  in  1  raw serial line from GPS, idle high, asynchronous to `clk`.
- `char`  out  8  last correctly framed byte; holds until the next good byte.
- `valid`  out  1  single-cycle strobe, high for exactly one clock when `char` updates.
- `frame_err`  out  1  single-cycle strobe when the stop bit samples low.
- `busy`  out  1  high from qualified start bit until return to IDLE.

## Operation
- `rx` passes through a 2-flop synchroniser (both flops reset to 1) giving `rx_s`; only `rx_s` is used internally.
- Bit-time counter `cnt`, width `$clog2(CLKS_PER_BIT)`; bit index `bit_idx` 3 bits; shift register `shreg` 8 bits.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: `cnt`=0; on `rx_s`==0 → START.
- START: `cnt` increments; at `cnt`==HALF-1: if `rx_s`==0 → DATA, `cnt`=0, `bit_idx`=0 (start qualified, `busy`=1); else → IDLE (glitch rejected, no output).
- DATA: `cnt` increments; at `cnt`==CLKS_PER_BIT-1: `shreg` <= {`rx_s`, `shreg[7:1]`}, `cnt`=0; if `bit_idx`==7 → STOP else `bit_idx`+1.
- STOP: at `cnt`==CLKS_PER_BIT-1: if `rx_s`==1 → `char`<=`shreg`, `valid`<=1, → IDLE; else `frame_err`<=1, → BREAK.
- BREAK: wait until `rx_s`==1, then → IDLE (prevents a held-low line from re-triggering start detection).
- `valid` and `frame_err` default low every cycle; never both high.
- No back-pressure: downstream must accept every `valid` strobe.

## Timing
- Reset (`rst`=0): state IDLE, `char`=8'h00, `valid`=0, `frame_err`=0, `busy`=0, `cnt`=0, `bit_idx`=0, `shreg`=0, synchroniser flops=1. Effective immediately, regardless of clock.
- Reset asserted mid-frame: frame discarded, no `valid`/`frame_err`; after release, receiver waits in IDLE for a fresh falling edge. A release while `rx` is low mid-byte may start a misaligned frame; a resulting bad stop bit is reported via `frame_err`.
- Latency: `valid` rises 2 + HALF + 9·CLKS_PER_BIT clocks (±1) after the `rx` falling edge of the start bit.
- Back-to-back bytes (stop bit immediately followed by next start bit) are received with no loss: IDLE is re-entered at the stop-bit midpoint, half a bit before the next start edge.
- Start-bit lows shorter than HALF clocks are ignored.
- Tolerates ±2% baud mismatch at 8N1 (sampling stays within the bit cell through the stop bit).
- `busy` falls in the same cycle the state returns to IDLE (or enters BREAK).

## Test plan
- Use `CLK_FREQ`=160, `BAUD`=10 (CLKS_PER_BIT=16, HALF=8) for all cases.
- Reset then send 8'h24 ('$') → `char`=8'h24, `valid` high exactly one cycle, 2+8+144 (±1) clocks after the start edge; `frame_err` stays 0.
- Send "GPRMC," (8'h47,50,52,4D,43,2C) back-to-back with no idle gap → six `valid` strobes, `char` values in order, none lost.
- Drive `rx` low for 5 clocks then high → no `valid`, no `frame_err`, `busy` never asserted; a following byte 8'hA5 is received correctly.
- Send 8'h3C with stop bit low, hold `rx` low for 40 clocks, then release → one `frame_err` strobe, no `valid`, `char` keeps its prior value, no spurious frame during the low period.
- Assert `rst` low during bit 4 of 8'hFF, release, then send 8'h0D → no output from the aborted frame; `char`=8'h0D with one `valid`.
- Send 8'h55 at 9.8 and 10.2 baud-equivalent bit periods → `char`=8'h55 each time, no `frame_err`.

Source files
------------

// File: rtl/gps_uart_rx.sv
// 8N1 serial receiver for the GPS NMEA stream: synchronises rx, qualifies the start bit,
// samples each bit at mid-cell and strobes every correctly framed byte out on char/valid.
`timescale 1ns/1ps

module gps_uart_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] char,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned HALF         = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       char_q, char_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
  logic             rx_s;

  // State and datapath registers; synchroniser resets to the idle-high line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shreg_q     <= 8'h00;
      char_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      char_q      <= char_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], rx};
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    char_d      = char_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    rx_s        = sync_q[1];

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        cnt_d = cnt_q + CNT_ONE;
        // Re-check the line half a bit in; anything shorter is treated as a glitch.
        if (cnt_q == CNT_MID) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          shreg_d = {rx_s, shreg_q[7:1]};
          cnt_d   = '0;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            char_d  = shreg_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Hold off start detection until the line has returned high.
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_DATA) || (state_d == S_STOP);
  end

  assign char      = char_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_gps_uart_rx.sv
// Self-checking bench for gps_uart_rx: drives serial frames on rx and compares the received
// byte stream, strobes and latency against a frame-level reference model.
`timescale 1ns/1ps

module tb_gps_uart_rx;

  localparam int unsigned CLK_FREQ = 160;
  localparam int unsigned BAUD     = 10;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
  localparam int unsigned HALF     = CPB / 2;
  localparam int          LAT      = 2 + HALF + 9 * CPB;
  localparam real         CLK_NS   = 10.0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] char;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int vectors = 0;
  int errors  = 0;

  gps_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .char      (char),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: running totals only, tests take snapshots and look at differences.
  logic [7:0] got_char[$];
  int         got_cyc[$];
  int         n_valid = 0, n_ferr = 0, n_busy = 0, n_both = 0, n_dbl = 0;
  logic       prev_valid = 1'b0;

  always @(negedge clk) begin
    if (valid) begin
      got_char.push_back(char);
      got_cyc.push_back(cyc);
      n_valid++;
      if (prev_valid) n_dbl++;
    end
    if (frame_err) n_ferr++;
    if (busy) n_busy++;
    if (valid && frame_err) n_both++;
    prev_valid = valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one 8N1 frame; bit_clks may be fractional to emulate baud mismatch.
  task automatic send_byte(input logic [7:0] d, input logic stop, input real bit_clks,
                           input bit align, output int start);
    real bns;
    bns = bit_clks * CLK_NS;
    if (align) begin
      @(posedge clk);
      #1;
    end
    start = cyc;
    rx = 1'b0;
    #(bns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bns);
    end
    rx = stop;
    #(bns);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset;
    #1 rst = 1'b0;
    #1;
    if (char !== 8'h00) begin errors++; $display("FAIL reset_char: got %h exp 00", char); end
    vectors++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid); end
    vectors++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b exp 0", frame_err); end
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    vectors++;
    wait_clks(3);
    @(negedge clk) rst = 1'b1;
    wait_clks(5);
  endtask

  task automatic test_single;
    int s, n0, f0, d0, lat;
    n0 = n_valid; f0 = n_ferr; d0 = n_dbl;
    send_byte(8'h24, 1'b1, real'(CPB), 1'b1, s);
    wait_clks(40);
    if (n_valid - n0 !== 1) begin errors++; $display("FAIL single_count: got %0d exp 1", n_valid - n0); end
    vectors++;
    if (n_valid - n0 >= 1) begin
      if (got_char[n0] !== 8'h24) begin errors++; $display("FAIL single_char: got %h exp 24", got_char[n0]); end
      vectors++;
      lat = got_cyc[n0] - s;
      if ((lat >= LAT - 1 && lat <= LAT + 1) !== 1'b1) begin
        errors++; $display("FAIL single_latency: got %0d exp %0d+-1", lat, LAT);
      end
      vectors++;
    end
    if (n_ferr - f0 !== 0) begin errors++; $display("FAIL single_ferr: got %0d exp 0", n_ferr - f0); end
    vectors++;
    if (n_dbl - d0 !== 0) begin errors++; $display("FAIL single_width: got %0d long strobes exp 0", n_dbl - d0); end
    vectors++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] msg [6];
    int st [6];
    int n0, lat;
    msg = '{8'h47, 8'h50, 8'h52, 8'h4D, 8'h43, 8'h2C};
    n0 = n_valid;
    for (int i = 0; i < 6; i++) send_byte(msg[i], 1'b1, real'(CPB), (i == 0), st[i]);
    wait_clks(40);
    if (n_valid - n0 !== 6) begin errors++; $display("FAIL b2b_count: got %0d exp 6", n_valid - n0); end
    vectors++;
    for (int i = 0; i < 6; i++) begin
      if (n0 + i < got_char.size()) begin
        if (got_char[n0 + i] !== msg[i]) begin
          errors++; $display("FAIL b2b_char[%0d]: got %h exp %h", i, got_char[n0 + i], msg[i]);
        end
        vectors++;
        lat = got_cyc[n0 + i] - st[i];
        if ((lat >= LAT - 1 && lat <= LAT + 1) !== 1'b1) begin
          errors++; $display("FAIL b2b_latency[%0d]: got %0d exp %0d+-1", i, lat, LAT);
        end
        vectors++;
      end
    end
  endtask

  task automatic test_glitch;
    int s, n0, f0, b0;
    n0 = n_valid; f0 = n_ferr; b0 = n_busy;
    @(posedge clk); #1 rx = 1'b0;
    wait_clks(5);
    #1 rx = 1'b1;
    wait_clks(60);
    if (n_valid - n0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d exp 0", n_valid - n0); end
    vectors++;
    if (n_ferr - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d exp 0", n_ferr - f0); end
    vectors++;
    if (n_busy - b0 !== 0) begin errors++; $display("FAIL glitch_busy: got %0d busy cycles exp 0", n_busy - b0); end
    vectors++;
    send_byte(8'hA5, 1'b1, real'(CPB), 1'b1, s);
    wait_clks(40);
    if (n_valid - n0 !== 1) begin errors++; $display("FAIL glitch_next_count: got %0d exp 1", n_valid - n0); end
    vectors++;
    if (char !== 8'hA5) begin errors++; $display("FAIL glitch_next_char: got %h exp a5", char); end
    vectors++;
  endtask

  task automatic test_frame_err;
    int s, n0, f0;
    n0 = n_valid; f0 = n_ferr;
    send_byte(8'h3C, 1'b0, real'(CPB), 1'b1, s);
    wait_clks(40);
    @(negedge clk);
    if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_in_break: got %b exp 0", busy); end
    vectors++;
    #1 rx = 1'b1;
    wait_clks(200);
    if (n_ferr - f0 !== 1) begin errors++; $display("FAIL ferr_count: got %0d exp 1", n_ferr - f0); end
    vectors++;
    if (n_valid - n0 !== 0) begin errors++; $display("FAIL ferr_valid: got %0d exp 0", n_valid - n0); end
    vectors++;
    if (char !== 8'hA5) begin errors++; $display("FAIL ferr_char_hold: got %h exp a5", char); end
    vectors++;
    if (n_both !== 0) begin errors++; $display("FAIL ferr_both: got %0d exp 0", n_both); end
    vectors++;
  endtask

  task automatic test_reset_midframe;
    int s, n0, f0;
    n0 = n_valid; f0 = n_ferr;
    fork
      send_byte(8'hFF, 1'b1, real'(CPB), 1'b1, s);
      begin
        wait_clks(90);
        #1;
        if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b exp 1", busy); end
        vectors++;
        rst = 1'b0;
        #1;
        if (char !== 8'h00) begin errors++; $display("FAIL rstmid_char: got %h exp 00", char); end
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
        vectors++;
        wait_clks(3);
        #2 rst = 1'b1;
      end
    join
    wait_clks(200);
    if (n_valid - n0 !== 0) begin errors++; $display("FAIL rstmid_valid: got %0d exp 0", n_valid - n0); end
    vectors++;
    if (n_ferr - f0 !== 0) begin errors++; $display("FAIL rstmid_ferr: got %0d exp 0", n_ferr - f0); end
    vectors++;
    send_byte(8'h0D, 1'b1, real'(CPB), 1'b1, s);
    wait_clks(40);
    if (n_valid - n0 !== 1) begin errors++; $display("FAIL rstmid_next_count: got %0d exp 1", n_valid - n0); end
    vectors++;
    if (char !== 8'h0D) begin errors++; $display("FAIL rstmid_next_char: got %h exp 0d", char); end
    vectors++;
  endtask

  task automatic test_baud_mismatch;
    real per [2];
    int s, n0, f0;
    per[0] = real'(CLK_FREQ) / 9.8;
    per[1] = real'(CLK_FREQ) / 10.2;
    for (int k = 0; k < 2; k++) begin
      n0 = n_valid; f0 = n_ferr;
      send_byte(8'h55, 1'b1, per[k], 1'b1, s);
      wait_clks(60);
      if (n_valid - n0 !== 1) begin errors++; $display("FAIL baud%0d_count: got %0d exp 1", k, n_valid - n0); end
      vectors++;
      if (char !== 8'h55) begin errors++; $display("FAIL baud%0d_char: got %h exp 55", k, char); end
      vectors++;
      if (n_ferr - f0 !== 0) begin errors++; $display("FAIL baud%0d_ferr: got %0d exp 0", k, n_ferr - f0); end
      vectors++;
    end
  endtask

  // Random bytes with random idle gaps (including none) against a queue of expected frames.
  task automatic test_random;
    logic [7:0] exp_q[$];
    int         st_q[$];
    int         n0, f0, s, gap, lat;
    logic [7:0] d;
    n0 = n_valid; f0 = n_ferr;
    for (int i = 0; i < 12; i++) begin
      d   = 8'($urandom);
      gap = (i == 0) ? 1 : int'($urandom_range(0, 30));
      if (gap > 0) wait_clks(gap);
      send_byte(d, 1'b1, real'(CPB), (gap > 0), s);
      exp_q.push_back(d);
      st_q.push_back(s);
    end
    wait_clks(40);
    if (n_valid - n0 !== exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d exp %0d", n_valid - n0, exp_q.size());
    end
    vectors++;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (n0 + i < got_char.size()) begin
        if (got_char[n0 + i] !== exp_q[i]) begin
          errors++; $display("FAIL rand_char[%0d]: got %h exp %h", i, got_char[n0 + i], exp_q[i]);
        end
        vectors++;
        lat = got_cyc[n0 + i] - st_q[i];
        if ((lat >= LAT - 1 && lat <= LAT + 1) !== 1'b1) begin
          errors++; $display("FAIL rand_latency[%0d]: got %0d exp %0d+-1", i, lat, LAT);
        end
        vectors++;
      end
    end
    if (n_ferr - f0 !== 0) begin errors++; $display("FAIL rand_ferr: got %0d exp 0", n_ferr - f0); end
    vectors++;
    if (n_dbl !== 0) begin errors++; $display("FAIL rand_width: got %0d long strobes exp 0", n_dbl); end
    vectors++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_baud_mismatch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
